// File: rtl/quad_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : quad_pkg
//  Purpose  : Shared phase/state types and Gray helpers for quad_decoder.
//  Revision : 1.0  initial release
// ============================================================================
package quad_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  // Forward Gray successor: 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t fwd_next(input phase_t p);
    phase_t r;
    case (p)
      PH_00:   r = PH_01;
      PH_01:   r = PH_11;
      PH_11:   r = PH_10;
      default: r = PH_00;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_decoder_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module   : sync_filter
//  Purpose  : Multi-flop synchroniser followed by a hold-time glitch filter.
//  Revision : 1.0  initial release
// ============================================================================
module sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic d_filt
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign d_filt = r_filt;

  // A new level is taken on the edge where it has differed for FILTER_CYCLES cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
      if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == FW'(FILTER_CYCLES - 1)) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + FW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : quad_decoder
//  Purpose  : Quadrature A/B front end producing incr/decr/err pulses.
//  Revision : 1.0  initial release
// ============================================================================
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  input  logic enable,
  output logic incr,
  output logic decr,
  output logic err,
  output logic dir,
  output logic ready
);

  localparam int SETTLE = SYNC_STAGES + FILTER_CYCLES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  logic          w_a_filt, w_b_filt;
  phase_t        w_phase;
  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_settle, w_settle_nxt;
  phase_t        r_prev, w_prev_nxt;
  logic          r_incr, r_decr, r_err, r_dir, r_ready;
  logic          w_incr_nxt, w_decr_nxt, w_err_nxt, w_dir_nxt, w_ready_nxt;

  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sync_a (
    .clk(clk), .reset(reset), .d_in(a_in), .d_filt(w_a_filt)
  );

  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sync_b (
    .clk(clk), .reset(reset), .d_in(b_in), .d_filt(w_b_filt)
  );

  assign w_phase = {w_a_filt, w_b_filt};

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_prev_nxt   = r_prev;
    w_incr_nxt   = 1'b0;
    w_decr_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_dir_nxt    = r_dir;
    w_ready_nxt  = r_ready;
    case (r_state)
      INIT: begin
        // Wait for the sync/filter pipeline to reflect the real input levels
        if (r_settle == SW'(SETTLE - 1)) begin
          w_state_nxt  = TRACK;
          w_settle_nxt = '0;
          w_prev_nxt   = w_phase;
          w_ready_nxt  = 1'b1;
        end else begin
          w_settle_nxt = r_settle + SW'(1);
        end
      end
      TRACK: begin
        w_prev_nxt = w_phase;
        if (w_phase != r_prev) begin
          if (fwd_next(r_prev) == w_phase) begin
            w_incr_nxt = enable;
            w_dir_nxt  = 1'b1;
          end else if (fwd_next(w_phase) == r_prev) begin
            w_decr_nxt = enable;
            w_dir_nxt  = 1'b0;
          end else begin
            w_err_nxt  = enable;
          end
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= INIT;
      r_settle <= '0;
      r_prev   <= PH_00;
      r_incr   <= 1'b0;
      r_decr   <= 1'b0;
      r_err    <= 1'b0;
      r_dir    <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_prev   <= w_prev_nxt;
      r_incr   <= w_incr_nxt;
      r_decr   <= w_decr_nxt;
      r_err    <= w_err_nxt;
      r_dir    <= w_dir_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign incr  = r_incr;
  assign decr  = r_decr;
  assign err   = r_err;
  assign dir   = r_dir;
  assign ready = r_ready;

endmodule
`default_nettype wire
